alu4_serial_engine: RTL and testbench

//  Sequential, bit-serial ALU engine that consumes the gate primitives (NOT/AND/OR/NAND/
//  NOR/XOR/XNOR). It accepts one operand pair and opcode over a valid/ready request port.
//  It evaluates the operation LSB-first, one bit per clock, and returns the result and

---
 rtl/alu4_serial_engine.sv | 100 ++++++++++
 tb/tb_alu4_serial_engine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu4_serial_engine.sv
// alu4_serial_engine: bit-serial ALU, LSB-first, one result bit per clock over valid/ready ports
module alu4_serial_engine #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_zero
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [2:0] OP_SUB = 3'b001;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, y_q, y_d;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic             c_q, in_ready_q, out_valid_q, carry_q, ovf_q, zero_q;
   logic             arith, b_bit, s_d, c_d, last;
   always_comb begin
      arith = op_q[2:1] == 2'b00;
      b_bit = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
      c_d   = (a_q[0] & b_bit) | (c_q & (a_q[0] ^ b_bit));
      s_d   = arith          ? a_q[0] ^ b_bit ^ c_q :
              op_q == 3'b010 ? a_q[0] & b_q[0] :
              op_q == 3'b011 ? a_q[0] | b_q[0] :
              op_q == 3'b100 ? a_q[0] ^ b_q[0] :
              op_q == 3'b101 ? ~(a_q[0] & b_q[0]) :
              op_q == 3'b110 ? ~(a_q[0] | b_q[0]) :
                               ~(a_q[0] ^ b_q[0]);
      y_d   = {s_d, res_q[WIDTH-1:1]};
      last  = cnt_q == LAST;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         op_q        <= '0;
         c_q         <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
               a_q        <= in_a;
               b_q        <= in_b;
               op_q       <= in_op;
               c_q        <= in_op == OP_SUB;
               cnt_q      <= '0;
               in_ready_q <= 1'b0;
               state_q    <= CALC;
            end
            CALC: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               res_q <= y_d;
               c_q   <= arith ? c_d : c_q;
               cnt_q <= cnt_q + 1'b1;
               if (last) begin
                  // overflow = carry into MSB (c_q) xor carry out of MSB (c_d)
                  y_q         <= y_d;
                  carry_q     <= arith & c_d;
                  ovf_q       <= arith & (c_q ^ c_d);
                  zero_q      <= y_d == '0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_y     = y_q;
   assign out_carry = carry_q;
   assign out_ovf   = ovf_q;
   assign out_zero  = zero_q;
endmodule

// File: tb/tb_alu4_serial_engine.sv
// tb_alu4_serial_engine: directed table, randomized model checks and handshake/reset corner cases
module tb_alu4_serial_engine;
   logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic       in_ready, out_valid, out_carry, out_ovf, out_zero;
   logic [2:0] in_op = '0;
   logic [3:0] in_a = '0, in_b = '0, out_y;
   int         n_cmp = 0, n_err = 0;

   alu4_serial_engine #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [3:0] a, b, y;
      logic       c, o, z;
   } vec_t;
   vec_t vt[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                 output logic [3:0] y, output logic c, output logic o, output logic z);
      logic [4:0] t;
      c = 1'b0;
      o = 1'b0;
      case (op)
         3'd0: begin
            t = {1'b0, a} + {1'b0, b};
            y = t[3:0];
            c = t[4];
            o = (a[3] == b[3]) && (y[3] != a[3]);
         end
         3'd1: begin
            y = a - b;
            c = a >= b;
            o = (a[3] != b[3]) && (y[3] != a[3]);
         end
         3'd2: y = a & b;
         3'd3: y = a | b;
         3'd4: y = a ^ b;
         3'd5: y = ~(a & b);
         3'd6: y = ~(a | b);
         default: y = ~(a ^ b);
      endcase
      z = y == 4'h0;
   endfunction

   task automatic start(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      int k = 0;
      while (!in_ready && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_op = op;
      in_a = a;
      in_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_op = 3'($urandom);
      in_a = 4'($urandom);
      in_b = 4'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] y, input logic c, input logic o, input logic z, input bit rdy_early);
      int lat;
      out_ready = rdy_early;
      start(op, a, b);
      wait_valid(lat);
      check({name, " latency"}, 32'(lat), 32'd4);
      check({name, " y"}, 32'(out_y), 32'(y));
      check({name, " carry"}, 32'(out_carry), 32'(c));
      check({name, " ovf"}, 32'(out_ovf), 32'(o));
      check({name, " zero"}, 32'(out_zero), 32'(z));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, " drop_valid"}, 32'(out_valid), 32'd0);
      check({name, " idle_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] y, ra, rb;
      logic       c, o, z, bad;
      logic [2:0] rop;
      int         lat;
      vt[0] = '{3'd0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0};
      vt[1] = '{3'd0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1};
      vt[2] = '{3'd1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0};
      vt[3] = '{3'd1, 4'h8, 4'h1, 4'h7, 1'b1, 1'b1, 1'b0};
      vt[4] = '{3'd2, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
      vt[5] = '{3'd3, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 1'b0};
      vt[6] = '{3'd4, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 1'b0};
      vt[7] = '{3'd5, 4'hC, 4'hA, 4'h7, 1'b0, 1'b0, 1'b0};
      vt[8] = '{3'd6, 4'hC, 4'hA, 4'h1, 1'b0, 1'b0, 1'b0};
      vt[9] = '{3'd7, 4'hC, 4'hA, 4'h9, 1'b0, 1'b0, 1'b0};
      #12;
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_y", 32'(out_y), 32'd0);
      check("rst flags", {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].y, vt[i].c, vt[i].o, vt[i].z, i[0]);

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra = 4'($urandom);
         rb = 4'($urandom);
         model(rop, ra, rb, y, c, o, z);
         run_op($sformatf("rnd%0d op%0d %h,%h", i, rop, ra, rb), rop, ra, rb, y, c, o, z, 1'($urandom));
      end

      out_ready = 1'b0;
      start(3'd0, 4'h5, 4'h6);
      wait_valid(lat);
      check("bp latency", 32'(lat), 32'd4);
      in_valid = 1'b1;
      in_op = 3'd1;
      in_a = 4'h9;
      in_b = 4'h2;
      bad = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_y !== 4'hB || in_ready !== 1'b0) bad = 1'b1;
      end
      check("bp hold", 32'(bad), 32'd0);
      check("bp y", 32'(out_y), 32'hB);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp release valid", 32'(out_valid), 32'd0);
      check("bp release ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("held accept", 32'(in_ready), 32'd0);
      wait_valid(lat);
      check("held latency", 32'(lat), 32'd4);
      check("held y", 32'(out_y), 32'h7);
      check("held carry", 32'(out_carry), 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("held done", 32'(in_ready), 32'd1);

      start(3'd0, 4'h3, 4'h4);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("mid rst valid", 32'(out_valid), 32'd0);
      check("mid rst ready", 32'(in_ready), 32'd1);
      @(negedge clk) rst = 1'b0;
      bad = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) bad = 1'b1;
      end
      check("mid rst no resp", 32'(bad), 32'd0);
      run_op("post rst", 3'd0, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
